// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT butterfly scheduler: controller state
// encoding, default transform size and the bit-reversal helper.
package fft_pkg;

    localparam int FFT_POINTS_DEF = 1024;
    localparam int ADDR_W_DEF     = $clog2(FFT_POINTS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_UNLOAD,
        ST_FIN
    } state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sched_ctrl_if.sv
// Handshake bundle between the FFT scheduler and its sample memory, butterfly
// engine and result reader; master is the scheduler side.
interface fft_sched_ctrl_if
    import fft_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              bf_valid;
    logic              bf_ready;
    logic [ADDR_W-1:0] bf_addr_a;
    logic [ADDR_W-1:0] bf_addr_b;
    logic [ADDR_W-2:0] bf_tw_idx;
    logic              bf_retire;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;

    modport master (
        input  start, in_valid, bf_ready, bf_retire, rd_ready,
        output busy, done, in_ready, mem_wr_en, mem_wr_addr,
               bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, rd_valid, rd_addr
    );

    modport slave (
        output start, in_valid, bf_ready, bf_retire, rd_ready,
        input  busy, done, in_ready, mem_wr_en, mem_wr_addr,
               bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, rd_valid, rd_addr
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly operand and twiddle index generator: purely
// combinational mapping of (stage, k) to the pair and its twiddle.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int STAGE_W = $clog2(ADDR_W_DEF)
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [ADDR_W-2:0]  k,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic [ADDR_W-2:0]  tw_idx
);

    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] low;

    always_comb begin
        k_ext  = {1'b0, k};
        half   = ADDR_W'(1) << stage;
        low    = k_ext & (half - 1'b1);
        // Group index bits of k move up one place to skip over the partner half.
        addr_a = ((k_ext & ~(half - 1'b1)) << 1) | low;
        addr_b = addr_a | half;
        tw_idx = (ADDR_W-1)'(low << (ADDR_W - 1 - int'(stage)));
    end

endmodule

// File: rtl/fft_sched_ctrl.sv
// FFT butterfly scheduler: loads samples in bit-reversed order, issues every
// butterfly stage by stage with a bounded in-flight window, then unloads.
module fft_sched_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_POINTS   = FFT_POINTS_DEF,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic             clk,
    input  logic             rst,
    fft_sched_ctrl_if.master bus
);

    localparam int ADDR_W  = $clog2(FFT_POINTS);
    localparam int STAGE_W = $clog2(ADDR_W);
    localparam int INF_W   = $clog2(MAX_INFLIGHT + 1);

    localparam logic [ADDR_W-1:0]  LAST_SAMPLE = ADDR_W'(FFT_POINTS - 1);
    localparam logic [ADDR_W-2:0]  LAST_K      = (ADDR_W-1)'(FFT_POINTS / 2 - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(ADDR_W - 1);
    localparam logic [INF_W-1:0]   MAX_INF     = INF_W'(MAX_INFLIGHT);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0]  unload_cnt_q, unload_cnt_d;
    logic [ADDR_W-2:0]  k_q, k_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;

    logic               issue;
    logic               retire;
    logic [ADDR_W-1:0]  gen_addr_a;
    logic [ADDR_W-1:0]  gen_addr_b;
    logic [ADDR_W-2:0]  gen_tw_idx;

    fft_addr_gen #(
        .ADDR_W (ADDR_W),
        .STAGE_W(STAGE_W)
    ) u_addr_gen (
        .stage (stage_q),
        .k     (k_q),
        .addr_a(gen_addr_a),
        .addr_b(gen_addr_b),
        .tw_idx(gen_tw_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= '0;
            unload_cnt_q <= '0;
            k_q          <= '0;
            stage_q      <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            unload_cnt_q <= unload_cnt_d;
            k_q          <= k_d;
            stage_q      <= stage_d;
            inflight_q   <= inflight_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        load_cnt_d      = load_cnt_q;
        unload_cnt_d    = unload_cnt_q;
        k_d             = k_q;
        stage_d         = stage_q;
        issue           = 1'b0;
        // A retire with nothing outstanding is stale and must not underflow.
        retire          = bus.bf_retire && (inflight_q != '0);

        bus.busy        = (state_q != ST_IDLE);
        bus.done        = 1'b0;
        bus.in_ready    = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.bf_valid    = 1'b0;
        bus.bf_addr_a   = '0;
        bus.bf_addr_b   = '0;
        bus.bf_tw_idx   = '0;
        bus.rd_valid    = 1'b0;
        bus.rd_addr     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                bus.in_ready    = 1'b1;
                bus.mem_wr_addr = ADDR_W'(bitrev(32'(load_cnt_q), ADDR_W));
                if (bus.in_valid) begin
                    bus.mem_wr_en = 1'b1;
                    load_cnt_d    = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_SAMPLE) begin
                        state_d = ST_COMPUTE;
                        stage_d = '0;
                        k_d     = '0;
                    end
                end
            end
            ST_COMPUTE: begin
                bus.bf_valid  = (inflight_q < MAX_INF);
                bus.bf_addr_a = gen_addr_a;
                bus.bf_addr_b = gen_addr_b;
                bus.bf_tw_idx = gen_tw_idx;
                issue         = bus.bf_valid && bus.bf_ready;
                if (issue) begin
                    k_d = k_q + 1'b1;
                    if (k_q == LAST_K) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Next stage reads this stage's results, so wait for every retire.
                if (inflight_q == '0) begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + 1'b1;
                        k_d     = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        unload_cnt_d = '0;
                        state_d      = ST_UNLOAD;
                    end
                end
            end
            ST_UNLOAD: begin
                bus.rd_valid = 1'b1;
                bus.rd_addr  = unload_cnt_q;
                if (bus.rd_ready) begin
                    unload_cnt_d = unload_cnt_q + 1'b1;
                    if (unload_cnt_q == LAST_SAMPLE) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d = inflight_q + INF_W'(issue) - INF_W'(retire);
    end

endmodule

// File: tb/tb_fft_sched_ctrl.sv
// Randomized self-checking bench for fft_sched_ctrl (8 points, window of 2)
// against a transaction-level model of the load/compute/unload flow.
module tb_fft_sched_ctrl;

    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int MAXI = 2;
    localparam int NBF  = (N / 2) * AW;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_COMP   = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_UNLOAD = 4;
    localparam int P_FIN    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_sched_ctrl_if #(.ADDR_W(AW)) bus();

    fft_sched_ctrl #(
        .FFT_POINTS  (N),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int m_phase    = P_IDLE;
    int m_loaded   = 0;
    int m_idx      = 0;
    int m_inflight = 0;
    int m_unloaded = 0;
    int ea[NBF];
    int eb[NBF];
    int etw[NBF];
    int eload[N];

    int lit_wr[N]   = '{0, 4, 2, 6, 1, 5, 3, 7};
    int lit_a[NBF]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b[NBF]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw[NBF] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // Stimulus controls
    int ready_mode = 0;
    int ret_mode   = 0;
    int inv_mode   = 0;
    int rdr_mode   = 0;
    bit noise      = 0;
    bit start_req  = 0;
    bit rst_req    = 1;
    bit [1:0] hist = 2'b00;

    // Observed DUT transactions
    int obs_a[$];
    int obs_b[$];
    int obs_tw[$];
    int obs_wr[$];
    int obs_rd[$];
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_model();
        int n;
        for (int x = 0; x < N; x++) begin
            int r;
            r = 0;
            for (int b = 0; b < AW; b++) r = r * 2 + ((x >> b) & 1);
            eload[x] = r;
        end
        n = 0;
        for (int s = 0; s < AW; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < N; g += 2 * half) begin
                for (int i = 0; i < half; i++) begin
                    ea[n]  = g + i;
                    eb[n]  = g + i + half;
                    etw[n] = i * ((N / 2) / half);
                    n++;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_b.delete(); obs_tw.delete();
        obs_wr.delete(); obs_rd.delete();
        done_cnt = 0;
    endtask

    // One clock: drive inputs, compare every output against the model, advance the model.
    task automatic step();
        bit ex_bfv, iss, ret;
        int inf0;
        @(negedge clk);
        rst = rst_req;
        bus.start    = start_req | (noise && ($urandom_range(0, 3) == 0));
        bus.in_valid = (inv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.bf_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (ret_mode)
            0:       bus.bf_retire = hist[1];
            1:       bus.bf_retire = ($urandom_range(0, 2) == 0);
            default: bus.bf_retire = ($urandom_range(0, 7) == 0);
        endcase
        bus.rd_ready = (rdr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        ex_bfv = (m_phase == P_COMP) && (m_inflight < MAXI);
        chk("busy",        bus.busy,        32'(m_phase != P_IDLE));
        chk("done",        bus.done,        32'(m_phase == P_FIN));
        chk("in_ready",    bus.in_ready,    32'(m_phase == P_LOAD));
        chk("mem_wr_en",   bus.mem_wr_en,   32'((m_phase == P_LOAD) && bus.in_valid));
        chk("mem_wr_addr", bus.mem_wr_addr, (m_phase == P_LOAD) ? eload[m_loaded] : 0);
        chk("bf_valid",    bus.bf_valid,    32'(ex_bfv));
        chk("bf_addr_a",   bus.bf_addr_a,   (m_phase == P_COMP) ? ea[m_idx] : 0);
        chk("bf_addr_b",   bus.bf_addr_b,   (m_phase == P_COMP) ? eb[m_idx] : 0);
        chk("bf_tw_idx",   bus.bf_tw_idx,   (m_phase == P_COMP) ? etw[m_idx] : 0);
        chk("rd_valid",    bus.rd_valid,    32'(m_phase == P_UNLOAD));
        chk("rd_addr",     bus.rd_addr,     (m_phase == P_UNLOAD) ? m_unloaded : 0);

        if (bus.mem_wr_en) obs_wr.push_back(int'(bus.mem_wr_addr));
        if (bus.bf_valid && bus.bf_ready) begin
            obs_a.push_back(int'(bus.bf_addr_a));
            obs_b.push_back(int'(bus.bf_addr_b));
            obs_tw.push_back(int'(bus.bf_tw_idx));
        end
        if (bus.rd_valid && bus.rd_ready) obs_rd.push_back(int'(bus.rd_addr));
        if (bus.done) done_cnt++;

        iss  = ex_bfv && bus.bf_ready;
        inf0 = m_inflight;
        ret  = bus.bf_retire && (inf0 > 0);
        hist = {hist[0], iss};
        if (rst_req) begin
            m_phase = P_IDLE; m_loaded = 0; m_idx = 0; m_inflight = 0; m_unloaded = 0;
        end else begin
            m_inflight = m_inflight + int'(iss) - int'(ret);
            case (m_phase)
                P_IDLE: if (bus.start) begin
                    m_phase = P_LOAD; m_loaded = 0; m_idx = 0; m_unloaded = 0;
                end
                P_LOAD: if (bus.in_valid) begin
                    m_loaded++;
                    if (m_loaded == N) m_phase = P_COMP;
                end
                P_COMP: if (iss) begin
                    m_idx++;
                    if (m_idx % (N / 2) == 0) m_phase = P_DRAIN;
                end
                P_DRAIN: if (inf0 == 0) m_phase = (m_idx == NBF) ? P_UNLOAD : P_COMP;
                P_UNLOAD: if (bus.rd_ready) begin
                    m_unloaded++;
                    if (m_unloaded == N) m_phase = P_FIN;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic run_xfer(input string tag);
        int c;
        clear_obs();
        start_req = 1; step(); start_req = 0;
        noise = 1;
        c = 0;
        while (m_phase != P_IDLE && c < 3000) begin
            step();
            c++;
        end
        noise = 0;
        chk({tag, "_finished_in_budget"}, 32'(c < 3000), 32'd1);
    endtask

    task automatic check_xfer(input string tag);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_writes"}, obs_wr.size(), N);
        chk({tag, "_issues"}, obs_a.size(), NBF);
        chk({tag, "_unloads"}, obs_rd.size(), N);
        foreach (obs_wr[i]) if (i < N) chk({tag, "_wr_seq"}, obs_wr[i], eload[i]);
        foreach (obs_a[i]) if (i < NBF) begin
            chk({tag, "_pair_a"}, obs_a[i], ea[i]);
            chk({tag, "_pair_b"}, obs_b[i], eb[i]);
            chk({tag, "_pair_tw"}, obs_tw[i], etw[i]);
        end
        foreach (obs_rd[i]) chk({tag, "_rd_seq"}, obs_rd[i], i);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.bf_ready = 1'b0;
        bus.bf_retire = 1'b0; bus.rd_ready = 1'b0;
        build_model();
        foreach (lit_wr[i]) chk("model_bitrev", eload[i], lit_wr[i]);
        foreach (lit_a[i]) begin
            chk("model_a", ea[i], lit_a[i]);
            chk("model_b", eb[i], lit_b[i]);
            chk("model_tw", etw[i], lit_tw[i]);
        end

        // Reset held with start high: reset wins, everything stays zero.
        rst_req = 1; start_req = 1;
        repeat (2) @(posedge clk);
        repeat (3) step();
        rst_req = 0; start_req = 0;
        step();

        // Directed: continuous load, always-ready, retire two cycles after issue.
        ready_mode = 0; ret_mode = 0; inv_mode = 0; rdr_mode = 0;
        run_xfer("directed");
        check_xfer("directed");
        foreach (obs_wr[i]) if (i < N) chk("directed_wr_literal", obs_wr[i], lit_wr[i]);
        foreach (obs_a[i]) if (i < NBF) begin
            chk("directed_a_literal", obs_a[i], lit_a[i]);
            chk("directed_tw_literal", obs_tw[i], lit_tw[i]);
        end

        // Sparse retires: window fills and bf_valid drops until a retire.
        ret_mode = 2;
        run_xfer("sparse_retire");
        check_xfer("sparse_retire");

        // Fully random handshakes, including stalls and simultaneous issue/retire.
        for (int t = 0; t < 4; t++) begin
            ready_mode = 1; ret_mode = 1 + (t % 2); inv_mode = 1; rdr_mode = 1;
            run_xfer("random");
            check_xfer("random");
        end

        // Reset in the middle of stage 1, then a clean transform.
        ready_mode = 0; ret_mode = 0; inv_mode = 0; rdr_mode = 0;
        clear_obs();
        start_req = 1; step(); start_req = 0;
        noise = 1;
        c = 0;
        while (!(m_phase == P_COMP && m_idx >= 5) && c < 500) begin
            step();
            c++;
        end
        noise = 0;
        chk("reached_stage1", 32'(c < 500), 32'd1);
        rst_req = 1; start_req = 1; step(); rst_req = 0; start_req = 0;
        step();
        chk("post_rst_busy", bus.busy, 32'd0);
        ret_mode = 1;
        repeat (6) step();
        chk("no_done_after_rst", done_cnt, 0);
        ret_mode = 0;
        repeat (2) step();
        run_xfer("after_rst");
        check_xfer("after_rst");

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
